// File: rtl/concat_stream_pkg.sv
// rtl/concat_stream_pkg.sv - shared defaults and FSM state type for the channel-concat stage.
package concat_stream_pkg;

  localparam int DATA_W_DEF     = 128;
  localparam int BEAT_CNT_W_DEF = 10;
  localparam int PIX_CNT_W_DEF  = 21;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PASS_A = 3'd2,
    PASS_B = 3'd3,
    DRAIN  = 3'd4
  } state_t;

endpackage

// File: rtl/concat_skid_buf.sv
// rtl/concat_skid_buf.sv - 2-entry ready/valid register slice carrying {last, data}.
// Upstream ready comes only from the skid register, so it never depends on i_m_ready.
module concat_skid_buf
  import concat_stream_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [W-1:0] o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready,
  output logic         o_drained
);

  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic [W-1:0] r_skid_data;
  logic         r_skid_valid;
  logic         w_take;
  logic         w_in_fire;

  assign w_take    = !r_out_valid || i_m_ready;
  assign w_in_fire = i_s_valid && !r_skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_take) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_data  <= i_s_data;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_data  <= i_s_data;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_s_ready = !r_skid_valid;
  assign o_m_data  = r_out_data;
  assign o_m_valid = r_out_valid;
  // Nothing left after this cycle: skid empty and output slot empty or being taken.
  assign o_drained = w_take && !r_skid_valid;

endmodule

// File: rtl/concat_stream.sv
// rtl/concat_stream.sv - per pixel forwards A beats then B beats as one stream with frame-end marker.
// Optional CONCAT_STALL_CNT_EN adds stall_cnt (busy cycles with output stalled).
module concat_stream
  import concat_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BEAT_CNT_W = BEAT_CNT_W_DEF,
  parameter int PIX_CNT_W  = PIX_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BEAT_CNT_W-1:0] cfg_a_beats,
  input  logic [BEAT_CNT_W-1:0] cfg_b_beats,
  input  logic [PIX_CNT_W-1:0]  cfg_pix_num,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_W-1:0]     b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
`ifdef CONCAT_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  state_t                r_state;
  logic [BEAT_CNT_W-1:0] r_a_beats;
  logic [BEAT_CNT_W-1:0] r_b_beats;
  logic [PIX_CNT_W-1:0]  r_pix_num;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [PIX_CNT_W-1:0]  r_pix_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_buf_ready;
  logic                  w_buf_drained;
  logic                  w_a_fire;
  logic                  w_b_fire;
  logic                  w_end_a;
  logic                  w_end_b;
  logic                  w_pix_end;
  logic                  w_in_last;
  logic [DATA_W-1:0]     w_in_data;
  logic [DATA_W:0]       w_out_word;

  assign a_ready  = (r_state == PASS_A) && w_buf_ready;
  assign b_ready  = (r_state == PASS_B) && w_buf_ready;
  assign w_a_fire = a_valid && a_ready;
  assign w_b_fire = b_valid && b_ready;

  assign w_end_a   = r_beat_cnt == r_a_beats - BEAT_CNT_W'(1);
  assign w_end_b   = r_beat_cnt == r_b_beats - BEAT_CNT_W'(1);
  assign w_pix_end = r_pix_cnt == r_pix_num - PIX_CNT_W'(1);
  assign w_in_last = w_pix_end && ((w_b_fire && w_end_b) ||
                                   (w_a_fire && w_end_a && (r_b_beats == '0)));
  assign w_in_data = w_a_fire ? a_data : b_data;

  concat_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_s_data  ({w_in_last, w_in_data}),
    .i_s_valid (w_a_fire || w_b_fire),
    .o_s_ready (w_buf_ready),
    .o_m_data  (w_out_word),
    .o_m_valid (m_valid),
    .i_m_ready (m_ready),
    .o_drained (w_buf_drained)
  );

  assign m_last = w_out_word[DATA_W];
  assign m_data = w_out_word[DATA_W-1:0];
  assign busy   = r_busy;
  assign done   = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a_beats  <= '0;
      r_b_beats  <= '0;
      r_pix_num  <= '0;
      r_beat_cnt <= '0;
      r_pix_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_beats  <= cfg_a_beats;
            r_b_beats  <= cfg_b_beats;
            r_pix_num  <= cfg_pix_num;
            r_beat_cnt <= '0;
            r_pix_cnt  <= '0;
            r_busy     <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (r_pix_num == '0 || (r_a_beats == '0 && r_b_beats == '0)) r_state <= DRAIN;
          else if (r_a_beats != '0)                                    r_state <= PASS_A;
          else                                                         r_state <= PASS_B;
        end
        PASS_A: begin
          if (w_a_fire) begin
            if (w_end_a) begin
              r_beat_cnt <= '0;
              if (r_b_beats != '0) begin
                r_state <= PASS_B;
              end else if (w_pix_end) begin
                r_state <= DRAIN;
              end else begin
                r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            end
          end
        end
        PASS_B: begin
          if (w_b_fire) begin
            if (w_end_b) begin
              r_beat_cnt <= '0;
              if (w_pix_end) begin
                r_state <= DRAIN;
              end else begin
                r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
                r_state   <= (r_a_beats != '0) ? PASS_A : PASS_B;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_buf_drained) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CONCAT_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_stall_cnt <= '0;
    end else if (r_busy && m_valid && !m_ready && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
